delay_sequencer: RTL and testbench

Command sequencer driving the handshake side of the delay generator: it walks a fixed init table (camera/display register writes), hands each command to a downstream writer over valid/ready, and between commands holds `en_delay` high until a programmed number of `delay_done` pulses (2 ms each at 100 MHz) have been counted. It sits between the top-level start logic and the peripheral writer in the object-detection front end.

---
 rtl/delay_seq_pkg.sv | 39 +++
 rtl/init_rom.sv | 54 +++++
 rtl/delay_sequencer.sv | 127 ++++++++++++
 tb/tb_delay_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_seq_pkg.sv
// -----------------------------------------------------------------------------
// delay_seq_pkg
// Shared definitions for the init-table delay sequencer:
//   - sequencer state encoding (legacy codes kept as localparams, typed enum)
//   - default entry field widths and packed entry width
//   - delay generator tick period (used by benches and timeout logic)
//   - idx_width(): table index width for a given table depth
// No ports.
// -----------------------------------------------------------------------------
package delay_seq_pkg;

    localparam int unsigned DEF_CMD_W   = 16;
    localparam int unsigned DEF_DLY_W   = 4;
    localparam int unsigned ENTRY_W     = DEF_DLY_W + DEF_CMD_W;

    // One delay_done tick per 200001 enabled cycles (2 ms at 100 MHz).
    localparam int unsigned DELAY_TICK_CYCLES = 200001;

    // Legacy state codes, kept so existing waveform decoders still match.
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_SEND     = 3'd2;
    localparam logic [2:0] S_WAIT_DLY = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = S_IDLE,
        ST_FETCH    = S_FETCH,
        ST_SEND     = S_SEND,
        ST_WAIT_DLY = S_WAIT_DLY,
        ST_DONE     = S_DONE
    } state_t;

    // Index width for a table of n entries; a 1-entry table still gets 1 bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/init_rom.sv
// -----------------------------------------------------------------------------
// init_rom
// Combinational init table for the delay sequencer. Each entry is
// {dly, cmd}: cmd is the word handed to the peripheral writer, dly the number
// of delay ticks to wait after it is accepted. Swap this file to retarget the
// sequencer at a different peripheral.
// Ports:
//   idx  in  IDX_W  table index
//   cmd  out CMD_W  command word of entry idx
//   dly  out DLY_W  delay-tick count of entry idx
// -----------------------------------------------------------------------------
module init_rom
    import delay_seq_pkg::*;
#(
    parameter  int unsigned NUM_CMDS = 16,
    parameter  int unsigned CMD_W    = 16,
    parameter  int unsigned DLY_W    = 4,
    localparam int unsigned IDX_W    = idx_width(NUM_CMDS)
) (
    input  logic [IDX_W-1:0] idx,
    output logic [CMD_W-1:0] cmd,
    output logic [DLY_W-1:0] dly
);

    logic [7:0]  addr;
    logic [19:0] raw;   // stored as {dly[3:0], cmd[15:0]}, resized on output

    always_comb begin
        addr = 8'(idx);
        raw  = '0;
        case (addr)
            8'd0:    raw = {4'd0,  16'hA001};   // sensor soft reset
            8'd1:    raw = {4'd2,  16'hB002};   // PLL config, needs lock time
            8'd2:    raw = {4'd0,  16'hC003};   // clock divider
            8'd3:    raw = {4'd15, 16'hD004};   // sensor power-up, long settle
            8'd4:    raw = {4'd1,  16'h3012};
            8'd5:    raw = {4'd0,  16'h3103};
            8'd6:    raw = {4'd3,  16'h3008};
            8'd7:    raw = {4'd0,  16'h3A00};
            8'd8:    raw = {4'd1,  16'h1280};   // display reset
            8'd9:    raw = {4'd0,  16'h1100};   // sleep out
            8'd10:   raw = {4'd0,  16'h0C00};
            8'd11:   raw = {4'd4,  16'h2900};   // display on
            8'd12:   raw = {4'd0,  16'h2C00};
            8'd13:   raw = {4'd2,  16'h3600};
            8'd14:   raw = {4'd0,  16'h3A55};
            8'd15:   raw = {4'd1,  16'h2980};
            default: raw = '0;
        endcase
        cmd = CMD_W'(raw[15:0]);
        dly = DLY_W'(raw[19:16]);
    end

endmodule

// File: rtl/delay_sequencer.sv
// -----------------------------------------------------------------------------
// delay_sequencer
// Walks the init table in init_rom, handing each command to a downstream
// writer over valid/ready and, between commands, holding en_delay high until
// the entry's programmed number of delay_done ticks has been counted.
// Ports:
//   clock       in   1      system clock (100 MHz)
//   reset_n     in   1      asynchronous active-low reset
//   start       in   1      run request, honoured in IDLE and DONE
//   cmd_valid   out  1      command word presented
//   cmd_data    out  CMD_W  command word
//   cmd_ready   in   1      downstream accepts
//   en_delay    out  1      enable to the delay generator
//   delay_done  in   1      single-cycle tick from the delay generator
//   busy        out  1      high in every state except IDLE and DONE
//   done        out  1      table completed; cleared by the next start
// All outputs are registered.
// -----------------------------------------------------------------------------
module delay_sequencer
    import delay_seq_pkg::*;
#(
    parameter  int unsigned NUM_CMDS = 16,
    parameter  int unsigned CMD_W    = 16,
    parameter  int unsigned DLY_W    = 4,
    localparam int unsigned IDX_W    = idx_width(NUM_CMDS)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    output logic             cmd_valid,
    output logic [CMD_W-1:0] cmd_data,
    input  logic             cmd_ready,
    output logic             en_delay,
    input  logic             delay_done,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CMDS - 1);
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [DLY_W-1:0] dly_cnt;
    logic [CMD_W-1:0] rom_cmd;
    logic [DLY_W-1:0] rom_dly;
    logic             entry_finished;

    init_rom #(
        .NUM_CMDS (NUM_CMDS),
        .CMD_W    (CMD_W),
        .DLY_W    (DLY_W)
    ) u_rom (
        .idx (idx),
        .cmd (rom_cmd),
        .dly (rom_dly)
    );

    // Current entry is complete: accepted with no delay, or its last tick seen.
    always_comb begin
        entry_finished = 1'b0;
        if (state == ST_SEND && cmd_valid && cmd_ready && dly_cnt == '0)
            entry_finished = 1'b1;
        if (state == ST_WAIT_DLY && delay_done && dly_cnt == DLY_ONE)
            entry_finished = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            dly_cnt   <= '0;
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
            en_delay  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_FETCH;
                        idx   <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    cmd_data  <= rom_cmd;
                    dly_cnt   <= rom_dly;
                    cmd_valid <= 1'b1;
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        if (dly_cnt != '0) begin
                            state    <= ST_WAIT_DLY;
                            en_delay <= 1'b1;
                        end
                    end
                end
                ST_WAIT_DLY: begin
                    if (delay_done) begin
                        dly_cnt <= dly_cnt - DLY_ONE;
                        if (dly_cnt == DLY_ONE)
                            en_delay <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Shared exit for SEND and WAIT_DLY; overrides the state set above.
            if (entry_finished) begin
                if (idx == LAST_IDX) begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end else begin
                    idx   <= idx + 1'b1;
                    state <= ST_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_delay_sequencer.sv
module tb_delay_sequencer;
    import delay_seq_pkg::*;

    localparam int unsigned N = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        cmd_ready = 1'b0;
    logic        inject_tick = 1'b0;
    logic        tick_pulse = 1'b0;
    logic        tick_en = 1'b0;
    logic        delay_done;
    logic        cmd_valid, en_delay, busy, done;
    logic [15:0] cmd_data;

    int errors = 0;
    int checks = 0;

    assign delay_done = inject_tick | tick_pulse;

    always #5 clock = ~clock;

    delay_sequencer #(
        .NUM_CMDS (N),
        .CMD_W    (16),
        .DLY_W    (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .en_delay   (en_delay),
        .delay_done (delay_done),
        .busy       (busy),
        .done       (done)
    );

    // Expected table contents (first N entries of the init table).
    logic [15:0] ref_cmd [N];
    int          ref_dly [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clock);
        #1;
    endtask

    // Behavioural delay generator: while enabled, one tick per random period.
    int gen_cnt = 0;
    int gen_per = 3;
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (!tick_en || !en_delay) begin
                gen_cnt    = 0;
                tick_pulse = 1'b0;
            end else if (gen_cnt >= gen_per - 1) begin
                tick_pulse = 1'b1;
                gen_cnt    = 0;
                gen_per    = int'($urandom_range(2, 6));
            end else begin
                tick_pulse = 1'b0;
                gen_cnt++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        st;
        logic        rdy;
        logic        dd;
        logic        valid;
        logic [15:0] data;
        logic        en;
        logic        bsy;
        logic        dn;
    } vec_t;

    function automatic vec_t mk(logic st, logic rdy, logic dd, logic valid,
                                logic [15:0] data, logic en, logic bsy, logic dn);
        vec_t v;
        v.st = st; v.rdy = rdy; v.dd = dd; v.valid = valid;
        v.data = data; v.en = en; v.bsy = bsy; v.dn = dn;
        return v;
    endfunction

    vec_t vecs [13];

    // Random-phase scoreboard state
    int  k;
    int  tick_seen;
    int  cur_dly;
    logic prev_en;
    logic done_seen;
    int  cycles;

    initial begin
        ref_cmd[0] = 16'hA001; ref_dly[0] = 0;
        ref_cmd[1] = 16'hB002; ref_dly[1] = 2;
        ref_cmd[2] = 16'hC003; ref_dly[2] = 0;
        ref_cmd[3] = 16'hD004; ref_dly[3] = 15;

        //            st rdy dd  valid data      en bsy dn
        vecs[0]  = mk(1, 1, 0,   0, 16'h0000, 0, 1, 0);  // IDLE -> FETCH
        vecs[1]  = mk(0, 1, 0,   1, 16'hA001, 0, 1, 0);  // SEND A001
        vecs[2]  = mk(0, 1, 0,   0, 16'hA001, 0, 1, 0);  // accepted -> FETCH
        vecs[3]  = mk(0, 1, 0,   1, 16'hB002, 0, 1, 0);  // SEND B002
        vecs[4]  = mk(0, 1, 0,   0, 16'hB002, 1, 1, 0);  // accepted -> WAIT
        vecs[5]  = mk(0, 0, 0,   0, 16'hB002, 1, 1, 0);
        vecs[6]  = mk(0, 0, 1,   0, 16'hB002, 1, 1, 0);  // tick 1 of 2
        vecs[7]  = mk(1, 0, 0,   0, 16'hB002, 1, 1, 0);  // start while busy
        vecs[8]  = mk(0, 0, 1,   0, 16'hB002, 0, 1, 0);  // tick 2 -> FETCH
        vecs[9]  = mk(0, 0, 0,   1, 16'hC003, 0, 1, 0);  // SEND C003
        vecs[10] = mk(0, 0, 1,   1, 16'hC003, 0, 1, 0);  // tick in SEND ignored
        vecs[11] = mk(0, 1, 0,   0, 16'hC003, 0, 1, 0);  // accepted -> FETCH
        vecs[12] = mk(0, 0, 0,   1, 16'hD004, 0, 1, 0);  // SEND D004

        // ---------------- reset state ----------------
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", 32'(cmd_valid), 0);
        check("rst_data",  32'(cmd_data),  0);
        check("rst_en",    32'(en_delay),  0);
        check("rst_busy",  32'(busy),      0);
        check("rst_done",  32'(done),      0);
        reset_n = 1'b1;
        tick_clk();
        check("idle_busy", 32'(busy), 0);

        // ---------------- table-driven basic run ----------------
        for (int unsigned i = 0; i < 13; i++) begin
            start       = vecs[i].st;
            cmd_ready   = vecs[i].rdy;
            inject_tick = vecs[i].dd;
            tick_clk();
            check($sformatf("v%0d_valid", i), 32'(cmd_valid), 32'(vecs[i].valid));
            check($sformatf("v%0d_data", i),  32'(cmd_data),  32'(vecs[i].data));
            check($sformatf("v%0d_en", i),    32'(en_delay),  32'(vecs[i].en));
            check($sformatf("v%0d_busy", i),  32'(busy),      32'(vecs[i].bsy));
            check($sformatf("v%0d_done", i),  32'(done),      32'(vecs[i].dn));
        end
        start = 1'b0;

        // ---------------- maximum delay (15 ticks), ticks in SEND ignored ----------------
        cmd_ready   = 1'b0;
        inject_tick = 1'b1;
        repeat (3) begin
            tick_clk();
            check("max_send_valid", 32'(cmd_valid), 1);
            check("max_send_en",    32'(en_delay),  0);
        end
        inject_tick = 1'b0;
        cmd_ready   = 1'b1;
        tick_clk();
        cmd_ready = 1'b0;
        check("max_en_rise", 32'(en_delay), 1);
        for (int t = 1; t <= 15; t++) begin
            inject_tick = 1'b1;
            tick_clk();
            inject_tick = 1'b0;
            check($sformatf("max_en_t%0d", t), 32'(en_delay), (t < 15) ? 1 : 0);
            tick_clk();
            check($sformatf("max_en_gap%0d", t), 32'(en_delay), (t < 15) ? 1 : 0);
        end
        check("max_done", 32'(done), 1);
        check("max_busy", 32'(busy), 0);

        // ---------------- restart from DONE with backpressure ----------------
        start = 1'b1;
        tick_clk();
        start = 1'b0;
        check("rs_done_clr", 32'(done),      0);
        check("rs_busy",     32'(busy),      1);
        check("rs_valid0",   32'(cmd_valid), 0);
        tick_clk();
        check("rs_valid", 32'(cmd_valid), 1);
        check("rs_data",  32'(cmd_data),  32'h0000A001);
        for (int c = 0; c < 5; c++) begin
            tick_clk();
            check($sformatf("bp_valid%0d", c), 32'(cmd_valid), 1);
            check($sformatf("bp_data%0d", c),  32'(cmd_data),  32'h0000A001);
        end
        cmd_ready = 1'b1;
        tick_clk();
        cmd_ready = 1'b0;
        check("bp_xfer_valid", 32'(cmd_valid), 0);
        tick_clk();
        check("bp_next_data", 32'(cmd_data),  32'h0000B002);
        check("bp_next_valid", 32'(cmd_valid), 1);
        cmd_ready = 1'b1;
        tick_clk();
        cmd_ready = 1'b0;
        check("wd_en", 32'(en_delay), 1);
        inject_tick = 1'b1;
        tick_clk();
        inject_tick = 1'b0;
        check("wd_en_after1", 32'(en_delay), 1);

        // ---------------- reset during WAIT_DLY ----------------
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_en",    32'(en_delay),  0);
        check("ar_busy",  32'(busy),      0);
        check("ar_valid", 32'(cmd_valid), 0);
        check("ar_done",  32'(done),      0);
        check("ar_data",  32'(cmd_data),  0);
        tick_clk();
        reset_n = 1'b1;
        start   = 1'b1;
        tick_clk();
        start = 1'b0;
        tick_clk();
        check("ar_restart_valid", 32'(cmd_valid), 1);
        check("ar_restart_data",  32'(cmd_data),  32'h0000A001);

        // ---------------- randomized runs against the scoreboard ----------------
        cmd_ready = 1'b0;
        reset_n   = 1'b0;
        tick_clk();
        reset_n = 1'b1;
        tick_en = 1'b1;
        for (int run = 0; run < 4; run++) begin
            start = 1'b1;
            tick_clk();
            start     = 1'b0;
            k         = 0;
            tick_seen = 0;
            cur_dly   = 0;
            prev_en   = 1'b0;
            done_seen = 1'b0;
            cycles    = 0;
            while (!done_seen && cycles < 3000) begin
                cmd_ready   = ($urandom_range(0, 9) < 6);
                inject_tick = !en_delay && ($urandom_range(0, 4) == 0);
                start       = busy && ($urandom_range(0, 15) == 0);
                @(negedge clock);
                if (cmd_valid && cmd_ready) begin
                    if (k < N) begin
                        check($sformatf("rnd%0d_cmd%0d", run, k), 32'(cmd_data), 32'(ref_cmd[k]));
                        cur_dly = ref_dly[k];
                    end else begin
                        check($sformatf("rnd%0d_extra_xfer", run), 32'(k), N - 1);
                    end
                    tick_seen = 0;
                    k++;
                end
                if (en_delay && delay_done)
                    tick_seen++;
                if (prev_en && !en_delay)
                    check($sformatf("rnd%0d_ticks_e%0d", run, k - 1), 32'(tick_seen), 32'(cur_dly));
                prev_en = en_delay;
                if (done)
                    done_seen = 1'b1;
                tick_clk();
                cycles++;
            end
            start       = 1'b0;
            inject_tick = 1'b0;
            cmd_ready   = 1'b0;
            check($sformatf("rnd%0d_done", run),   32'(done_seen), 1);
            check($sformatf("rnd%0d_count", run),  32'(k),         N);
            check($sformatf("rnd%0d_busy", run),   32'(busy),      0);
            check($sformatf("rnd%0d_en_off", run), 32'(en_delay),  0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
